truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential stimulus-and-capture stage placed directly upstream of the team's 4-input combinational function blocks (output F, inputs A, B, C, D). It performs the following steps:
- Drives all 16 input combinations in ascending order and holds each for a programmable number of cycles.
- Samples the block's F response at the end of each hold and assembles a 16-bit truth table.
- Compares the table against an expected table latched at start.

This replaces hand-written sweep loops with a synthesizable, self-checking sweep engine.

## Interface
- HOLD_CYCLES, default 3: cycles each input vector is held before F is sampled; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a sweep; honoured only in IDLE.
- exp_table  input  16  expected truth table; bit i = expected F for input value i; latched on accepted start.
- f_in  input  1  F output of the block under sweep; combinational function of abcd.
- abcd  output  4  drive vector; bit3=A, bit2=B, bit1=C, bit0=D.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  16  captured truth table; bit i = sampled F for input value i.
- ones_count  output  5  number of captured minterms (0..16).
- mismatch  output  1  table_out differs from latched exp_table; valid from done onward.
- first_fail  output  4  lowest index i where table_out[i] != exp_table[i]; 0 when no mismatch.

## Operation
- States are IDLE, RUN, and DONE.
- Reset (any state, including mid-RUN) forces the following values at the next edge:
  - state = IDLE.
  - abcd, busy, done, table_out, ones_count, mismatch, and first_fail all = 0.
  - The hold counter and latched expected table both = 0.
- IDLE → RUN when start=1:
  - Latch exp_table.
  - Clear table_out, ones_count, mismatch, first_fail, and the hold counter.
  - Set abcd = 0 and busy = 1.
- RUN behaviour:
  - The hold counter counts 0..HOLD_CYCLES-1.
  - When the counter reaches HOLD_CYCLES-1, the next edge does all of the following:
    - Writes table_out[abcd] = f_in.
    - Increments ones_count if f_in = 1.
    - Updates mismatch/first_fail.
    - Resets the counter to 0.
  - On that same edge, the state machine either:
    - sets abcd = abcd+1, if abcd < 15; or
    - moves to DONE with abcd = 0 and busy = 0, if abcd = 15.
- Compare rule at each sample:
  - If f_in != latched bit [abcd] and mismatch = 0, set mismatch = 1 and first_fail = abcd.
  - Ascending order guarantees first_fail is the lowest failing index.
- DONE: done = 1 for exactly one cycle, then unconditionally → IDLE. start is ignored in DONE.
- start while in RUN or DONE is ignored; no restart and no effect on the exp_table latch.
- Results (table_out, ones_count, mismatch, first_fail) hold their values in IDLE until the next accepted start or reset.
- exp_table changes after start have no effect.
- ones_count width is 5 bits; 16 is representable, so it never wraps.
- abcd wrap 15→0 happens only on the RUN→DONE transition.

## Timing
- Let start be sampled high in IDLE at edge k.
- Vector i is driven on abcd from edge k+i·H to edge k+(i+1)·H, where H = HOLD_CYCLES.
- f_in for vector i is sampled at edge k+(i+1)·H. f_in must be settled within H cycles of the abcd change; the block adds no input register.
- done is high between edges k+16H and k+16H+1.
- table_out, ones_count, mismatch, and first_fail are final when done is high.
- busy is high between edges k and k+16H.
- The earliest next accepted start is at edge k+16H+1; that is, the shortest start-to-start interval is 16H+1 cycles.
- A reset asserted at any edge overrides start and every in-progress transition at that edge.

## Test plan
- Reset values: hold rst=1 for 2 cycles with start=1. Required: after release, state IDLE and every output = 0; done never pulses.
- Identity sweep: f_in tied to abcd[3] (F=A), HOLD_CYCLES=3, exp_table=16'hFF00, start pulse at edge k. Required:
  - abcd steps 0..15 every 3 cycles.
  - done at edge k+48.
  - table_out = 16'hFF00, ones_count = 8, mismatch = 0, first_fail = 0.
- Mismatch detection: F = A·B + C·D (table 16'hF888), exp_table = 16'hF880. Required: table_out = 16'hF888, ones_count = 7, mismatch = 1, first_fail = 3.
- Minimum hold: HOLD_CYCLES=1, f_in tied to 1, exp_table = 16'hFFFF. Required:
  - abcd changes every cycle.
  - done exactly 16 cycles after start.
  - ones_count = 16, table_out = 16'hFFFF, mismatch = 0.
- Start while busy: pulse start again at k+10 and change exp_table at k+5. Required: no restart, done still at k+16H, comparison uses the exp_table latched at k.
- Reset mid-run: assert rst at edge k+20. Required:
  - At k+21: busy = 0, abcd = 0, table_out = 0, ones_count = 0.
  - No done pulse follows.
  - A new start then completes a normal full sweep.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Sweep engine for 4-input combinational blocks: drives abcd 0..15, samples F after
// each hold window, builds the truth table and compares it against a latched expectation.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] exp_table,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count,
  output logic        mismatch,
  output logic [3:0]  first_fail
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [15:0]      exp_lat;

  logic sample_c;
  logic last_c;
  logic miss_c;

  assign sample_c = (state == S_RUN) && (hold_cnt == HOLD_LAST);
  assign last_c   = sample_c && (abcd == 4'd15);
  assign miss_c   = f_in != exp_lat[abcd];

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered status outputs, drive vector, capture and compare datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      abcd       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= 16'd0;
      ones_count <= 5'd0;
      mismatch   <= 1'b0;
      first_fail <= 4'd0;
      hold_cnt   <= '0;
      exp_lat    <= 16'd0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_lat    <= exp_table;
            table_out  <= 16'd0;
            ones_count <= 5'd0;
            mismatch   <= 1'b0;
            first_fail <= 4'd0;
            hold_cnt   <= '0;
            abcd       <= 4'd0;
          end
        end
        S_RUN: begin
          if (sample_c) begin
            table_out[abcd] <= f_in;
            ones_count      <= ones_count + 5'(f_in);
            if (miss_c && !mismatch) begin
              mismatch   <= 1'b1;
              first_fail <= abcd;
            end
            hold_cnt <= '0;
            // 15 -> 0 wrap coincides with the move to DONE
            abcd     <= abcd + 4'd1;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweeper instances (hold 3 and hold 1); the driver queues the
// expected result per sweep and a monitor checks it on done plus the abcd/busy timeline.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst;
  logic        start3, start1;
  logic [15:0] exp3, exp1;
  logic        f3, f1;
  logic        mode;
  logic [3:0]  abcd3, abcd1;
  logic        busy3, busy1, done3, done1, mm3, mm1;
  logic [15:0] tout3, tout1;
  logic [4:0]  ones3, ones1;
  logic [3:0]  ff3, ff1;

  typedef struct {
    int          done_cyc;
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic        mm;
    logic [3:0]  ff;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];
  exp_t e3, e1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int k3 = 0;
  int k1 = 0;
  bit trk3 = 0;
  bit trk1 = 0;

  truth_table_sweeper #(.HOLD_CYCLES(3)) u_h3 (
    .clk(clk), .rst(rst), .start(start3), .exp_table(exp3), .f_in(f3),
    .abcd(abcd3), .busy(busy3), .done(done3), .table_out(tout3),
    .ones_count(ones3), .mismatch(mm3), .first_fail(ff3)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .start(start1), .exp_table(exp1), .f_in(f1),
    .abcd(abcd1), .busy(busy1), .done(done1), .table_out(tout1),
    .ones_count(ones1), .mismatch(mm1), .first_fail(ff1)
  );

  // mode 0: F = A ; mode 1: F = A&B | C&D
  assign f3 = mode ? ((abcd3[3] & abcd3[2]) | (abcd3[1] & abcd3[0])) : abcd3[3];
  assign f1 = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: result checks on done, timeline checks while a sweep is tracked
  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        chk("unexpected_done_h3", 32'(done3), 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("done_cycle_h3", cyc, e3.done_cyc);
        chk("table_h3", 32'(tout3), 32'(e3.tbl));
        chk("ones_h3", 32'(ones3), 32'(e3.ones));
        chk("mismatch_h3", 32'(mm3), 32'(e3.mm));
        chk("first_fail_h3", 32'(ff3), 32'(e3.ff));
        chk("busy_at_done_h3", 32'(busy3), 32'd0);
        chk("abcd_at_done_h3", 32'(abcd3), 32'd0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done_h1", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("done_cycle_h1", cyc, e1.done_cyc);
        chk("table_h1", 32'(tout1), 32'(e1.tbl));
        chk("ones_h1", 32'(ones1), 32'(e1.ones));
        chk("mismatch_h1", 32'(mm1), 32'(e1.mm));
        chk("first_fail_h1", 32'(ff1), 32'(e1.ff));
        chk("busy_at_done_h1", 32'(busy1), 32'd0);
      end
    end
    if (trk3 && cyc >= k3 && cyc < k3 + 48) begin
      chk("abcd_h3", 32'(abcd3), 32'((cyc - k3) / 3));
      chk("busy_h3", 32'(busy3), 32'd1);
    end
    if (trk1 && cyc >= k1 && cyc < k1 + 16) begin
      chk("abcd_h1", 32'(abcd1), 32'(cyc - k1));
      chk("busy_h1", 32'(busy1), 32'd1);
    end
  end

  task automatic go3(input logic [15:0] et, input logic [15:0] tbl, input logic [4:0] ones,
                     input logic mm, input logic [3:0] ff);
    exp_t e;
    e.done_cyc = cyc + 1 + 48;
    e.tbl = tbl; e.ones = ones; e.mm = mm; e.ff = ff;
    q3.push_back(e);
    k3 = cyc + 1;
    trk3 = 1'b1;
    exp3 = et;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic go1(input logic [15:0] et, input logic [15:0] tbl, input logic [4:0] ones,
                     input logic mm, input logic [3:0] ff);
    exp_t e;
    e.done_cyc = cyc + 1 + 16;
    e.tbl = tbl; e.ones = ones; e.mm = mm; e.ff = ff;
    q1.push_back(e);
    k1 = cyc + 1;
    trk1 = 1'b1;
    exp1 = et;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q3.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(q3.size() + q1.size()), 32'd0);
    trk3 = 1'b0;
    trk1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start3 = 1'b1; start1 = 1'b1;
    exp3 = 16'hFFFF; exp1 = 16'hFFFF; mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start3 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst_abcd_h3", 32'(abcd3), 32'd0);
    chk("rst_busy_h3", 32'(busy3), 32'd0);
    chk("rst_done_h3", 32'(done3), 32'd0);
    chk("rst_table_h3", 32'(tout3), 32'd0);
    chk("rst_ones_h3", 32'(ones3), 32'd0);
    chk("rst_mm_h3", 32'(mm3), 32'd0);
    chk("rst_ff_h3", 32'(ff3), 32'd0);
    chk("rst_abcd_h1", 32'(abcd1), 32'd0);
    chk("rst_busy_h1", 32'(busy1), 32'd0);
    chk("rst_table_h1", 32'(tout1), 32'd0);
    chk("rst_ones_h1", 32'(ones1), 32'd0);

    // Identity sweep F = A
    mode = 1'b0;
    go3(16'hFF00, 16'hFF00, 5'd8, 1'b0, 4'd0);
    drain("drain_identity");
    repeat (3) @(negedge clk);
    chk("hold_table_idle", 32'(tout3), 32'hFF00);
    chk("hold_ones_idle", 32'(ones3), 32'd8);

    // Mismatch plus ignored restart and late exp_table change
    mode = 1'b1;
    go3(16'hF880, 16'hF888, 5'd7, 1'b1, 4'd3);
    repeat (4) @(negedge clk);
    exp3 = 16'hF888;
    repeat (5) @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    drain("drain_mismatch");

    // Minimum hold, all ones; then a failure only at index 15
    go1(16'hFFFF, 16'hFFFF, 5'd16, 1'b0, 4'd0);
    drain("drain_min_hold");
    go1(16'h7FFF, 16'hFFFF, 5'd16, 1'b1, 4'd15);
    drain("drain_fail_at_15");

    // Reset mid-run at edge k+20
    mode = 1'b0;
    go3(16'hFF00, 16'hFF00, 5'd8, 1'b0, 4'd0);
    repeat (19) @(negedge clk);
    trk3 = 1'b0;
    q3.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy3), 32'd0);
    chk("midrst_abcd", 32'(abcd3), 32'd0);
    chk("midrst_table", 32'(tout3), 32'd0);
    chk("midrst_ones", 32'(ones3), 32'd0);
    repeat (60) @(negedge clk);
    go3(16'hFF01, 16'hFF00, 5'd8, 1'b1, 4'd0);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
